usb_slave_regs: RTL and testbench

USB_SLAVE_REGS -- requirements
Module: usb_slave_regs

---
 rtl/usb_slave_regs.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_usb_slave_regs.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_slave_regs.sv
// rtl/usb_slave_regs.sv - AHB-side register file and byte serializer for a USB slave endpoint
//
// Purpose:
//   Decodes latched AHB register accesses. Reads and writes at address 0x0 are
//   moved byte by byte between the bus word and the endpoint FIFO by a small
//   IDLE/XFER/DONE serializer. All other addresses go to the status, error,
//   occupancy, tx_control and flush registers.
//
// Ports:
//   clk, n_rst            clock (rising edge) and asynchronous active-low reset
//   haddr_reg, hsize_reg  latched AHB address and transfer size
//   hwrite_reg            latched AHB write flag
//   xfer_valid            one-cycle data-phase strobe
//   hwdata / hrdata       AHB write and read data
//   rx_packet             decoded packet id (0 DATA, 1 IN, 2 OUT, 3 ACK, 4 NAK)
//   rx_data_ready         rx_packet is valid this cycle
//   rx_transfer_active    receiver busy
//   rx_error, tx_error    error strobes from the USB engines
//   tx_transfer_active    transmitter busy
//   rx_data               FIFO read data
//   buffer_occupancy      FIFO fill level in bytes
//   get_rx_data           FIFO pop strobe
//   store_tx_data         FIFO push strobe, with the byte on tx_data
//   clear                 FIFO flush request
//   hold                  stalls the bus while the serializer is busy
//   err_resp              one-cycle error response for a refused transfer
//   d_mode                follows tx_transfer_active
//   tx_packet             packet type requested from the transmitter
module usb_slave_regs #(
    parameter int BUS_BYTES  = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int OCC_W      = 7
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [3:0]             haddr_reg,
    input  logic [1:0]             hsize_reg,
    input  logic                   hwrite_reg,
    input  logic                   xfer_valid,
    input  logic [8*BUS_BYTES-1:0] hwdata,
    input  logic [2:0]             rx_packet,
    input  logic                   rx_data_ready,
    input  logic                   rx_transfer_active,
    input  logic                   rx_error,
    input  logic                   tx_transfer_active,
    input  logic                   tx_error,
    input  logic [7:0]             rx_data,
    input  logic [OCC_W-1:0]       buffer_occupancy,
    output logic                   get_rx_data,
    output logic                   store_tx_data,
    output logic                   clear,
    output logic                   hold,
    output logic                   err_resp,
    output logic                   d_mode,
    output logic [7:0]             tx_data,
    output logic [1:0]             tx_packet,
    output logic [8*BUS_BYTES-1:0] hrdata
);

    localparam int DW = 8 * BUS_BYTES;
    localparam int OW = OCC_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [2:0]      n_q, n_d;
    logic            write_q, write_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rbuf_q, rbuf_d;
    logic            err_resp_q, err_resp_d;

    logic            occ_nz_q, occ_nz_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [3:0]      pkt_q, pkt_d;      // {NAK, ACK, OUT, IN}
    logic            rx_act_q, rx_act_d;
    logic            tx_act_q, tx_act_d;
    logic            rx_err_q, rx_err_d;
    logic            tx_err_q, tx_err_d;
    logic [7:0]      txc_q, txc_d;
    logic [7:0]      flush_q, flush_d;

    logic [3:0]      pow_n;
    logic [2:0]      n_cur;
    logic [OW-1:0]   occ_ext, n_ext;
    logic            xfer_err, buf_req, reg_wr, reg_rd, rd_err_reg;
    logic [15:0]     status_val, error_val, reg_val;
    logic [31:0]     reg_val32;

    // Byte count of this access: the transfer size clipped to the bus width.
    always_comb begin
        pow_n = 4'd1 << hsize_reg;
        if (pow_n > 4'(BUS_BYTES)) begin
            n_cur = 3'(BUS_BYTES);
        end else begin
            n_cur = pow_n[2:0];
        end
    end

    // Refuse reads that would underrun the FIFO and writes that would overrun
    // it; the sum is formed one bit wider so a full FIFO cannot wrap.
    always_comb begin
        occ_ext  = {1'b0, buffer_occupancy};
        n_ext    = OW'(n_cur);
        xfer_err = hwrite_reg ? ((occ_ext + n_ext) > OW'(FIFO_DEPTH))
                              : (occ_ext < n_ext);
        buf_req    = (state_q == IDLE) && xfer_valid && (haddr_reg == 4'h0);
        reg_wr     = (state_q == IDLE) && xfer_valid && (haddr_reg != 4'h0) && hwrite_reg;
        reg_rd     = (state_q == IDLE) && xfer_valid && (haddr_reg != 4'h0) && !hwrite_reg;
        rd_err_reg = reg_rd && (haddr_reg == 4'h6);
    end

    // Serializer next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        err_resp_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_req) begin
                    if (xfer_err) begin
                        err_resp_d = 1'b1;
                    end else begin
                        state_d = XFER;
                        cnt_d   = 2'd0;
                        n_d     = n_cur;
                        write_d = hwrite_reg;
                        wdata_d = hwdata;
                        rbuf_d  = '0;
                    end
                end
            end
            XFER: begin
                // The FIFO presents the popped byte during the pop cycle.
                if (!write_q) begin
                    for (int i = 0; i < BUS_BYTES; i++) begin
                        if (cnt_q == 2'(i)) begin
                            rbuf_d[8*i +: 8] = rx_data;
                        end
                    end
                end
                if ({1'b0, cnt_q} == (n_q - 3'd1)) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file next state.
    always_comb begin
        occ_nz_d = (buffer_occupancy != '0);
        occ_d    = buffer_occupancy;
        rx_act_d = rx_transfer_active;
        tx_act_d = tx_transfer_active;

        pkt_d = pkt_q;
        if (rx_data_ready) begin
            case (rx_packet)
                3'd1:    pkt_d = 4'b0001;
                3'd2:    pkt_d = 4'b0010;
                3'd3:    pkt_d = 4'b0100;
                3'd4:    pkt_d = 4'b1000;
                default: pkt_d = pkt_q;
            endcase
        end

        // A new error in the clear-on-read cycle must survive the clear.
        rx_err_d = (rx_err_q && !rd_err_reg) || rx_error;
        tx_err_d = (tx_err_q && !rd_err_reg) || tx_error;

        // tx_control drops on the rising edge of tx_transfer_active unless
        // the bus rewrites it in that very cycle.
        txc_d = txc_q;
        if (tx_transfer_active && !tx_act_q) begin
            txc_d = 8'h00;
        end
        if (reg_wr && (haddr_reg == 4'hC)) begin
            txc_d = hwdata[7:0];
        end

        flush_d = flush_q;
        if ((flush_q != 8'h00) && (buffer_occupancy == '0)) begin
            flush_d = 8'h00;
        end
        if (reg_wr && (haddr_reg == 4'hD) && (hwdata[7:0] != 8'h00)) begin
            flush_d = hwdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            err_resp_q <= 1'b0;
            occ_nz_q   <= 1'b0;
            occ_q      <= '0;
            pkt_q      <= '0;
            rx_act_q   <= 1'b0;
            tx_act_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            txc_q      <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            err_resp_q <= err_resp_d;
            occ_nz_q   <= occ_nz_d;
            occ_q      <= occ_d;
            pkt_q      <= pkt_d;
            rx_act_q   <= rx_act_d;
            tx_act_q   <= tx_act_d;
            rx_err_q   <= rx_err_d;
            tx_err_q   <= tx_err_d;
            txc_q      <= txc_d;
            flush_q    <= flush_d;
        end
    end

    // Outputs.
    always_comb begin
        hold          = (state_q != IDLE);
        get_rx_data   = (state_q == XFER) && !write_q;
        store_tx_data = (state_q == XFER) && write_q;
        err_resp      = err_resp_q;
        clear         = (flush_q != 8'h00);
        tx_packet     = txc_q[1:0];
        d_mode        = tx_transfer_active;

        tx_data = 8'h00;
        if (store_tx_data) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                if (cnt_q == 2'(i)) begin
                    tx_data = wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Read mux: buffer data in DONE, register data in the strobe cycle.
    always_comb begin
        status_val = {6'b0, tx_act_q, rx_act_q, 3'b0, pkt_q, occ_nz_q};
        error_val  = {7'b0, tx_err_q, 7'b0, rx_err_q};
        reg_val    = 16'h0000;
        case (haddr_reg)
            4'h4: reg_val = status_val;
            4'h5: reg_val = {8'h00, status_val[15:8]};
            4'h6: reg_val = error_val;
            4'h7: reg_val = {8'h00, error_val[15:8]};
            4'h8: reg_val[OCC_W-1:0] = occ_q;
            4'hC: reg_val = {8'h00, txc_q};
            4'hD: reg_val = {8'h00, flush_q};
            default: reg_val = 16'h0000;
        endcase
        reg_val32 = {16'h0000, reg_val};

        hrdata = '0;
        if ((state_q == DONE) && !write_q) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                if (3'(i) < n_q) begin
                    hrdata[8*i +: 8] = rbuf_q[8*i +: 8];
                end
            end
        end else if (reg_rd) begin
            hrdata = reg_val32[DW-1:0];
        end
    end

endmodule

// File: tb/tb_usb_slave_regs.sv
// tb/tb_usb_slave_regs.sv - self-checking bench for usb_slave_regs
module tb_usb_slave_regs;

    logic        clk;
    logic        n_rst;
    logic [3:0]  haddr_reg;
    logic [1:0]  hsize_reg;
    logic        hwrite_reg;
    logic        xfer_valid;
    logic [31:0] hwdata;
    logic [2:0]  rx_packet;
    logic        rx_data_ready;
    logic        rx_transfer_active;
    logic        rx_error;
    logic        tx_transfer_active;
    logic        tx_error;
    logic [7:0]  rx_data;
    logic [6:0]  buffer_occupancy;
    logic        get_rx_data;
    logic        store_tx_data;
    logic        clear;
    logic        hold;
    logic        err_resp;
    logic        d_mode;
    logic [7:0]  tx_data;
    logic [1:0]  tx_packet;
    logic [31:0] hrdata;

    int checks = 0;
    int errors = 0;

    usb_slave_regs #(
        .BUS_BYTES (4),
        .FIFO_DEPTH(64),
        .OCC_W     (7)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .haddr_reg         (haddr_reg),
        .hsize_reg         (hsize_reg),
        .hwrite_reg        (hwrite_reg),
        .xfer_valid        (xfer_valid),
        .hwdata            (hwdata),
        .rx_packet         (rx_packet),
        .rx_data_ready     (rx_data_ready),
        .rx_transfer_active(rx_transfer_active),
        .rx_error          (rx_error),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .rx_data           (rx_data),
        .buffer_occupancy  (buffer_occupancy),
        .get_rx_data       (get_rx_data),
        .store_tx_data     (store_tx_data),
        .clear             (clear),
        .hold              (hold),
        .err_resp          (err_resp),
        .d_mode            (d_mode),
        .tx_data           (tx_data),
        .tx_packet         (tx_packet),
        .hrdata            (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  pkt;
        logic        rdy;
        logic        rxe;
        logic        txe;
        logic        rxa;
        logic        txa;
        logic [6:0]  occ;
        logic        xv;
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  wd;
        logic [15:0] exp_rd;
        logic [1:0]  exp_txp;
    } vec_t;

    vec_t tbl[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        haddr_reg = 4'h0; hsize_reg = 2'd0; hwrite_reg = 1'b0; xfer_valid = 1'b0;
        hwdata = 32'h0; rx_packet = 3'd0; rx_data_ready = 1'b0;
        rx_transfer_active = 1'b0; rx_error = 1'b0; tx_transfer_active = 1'b0;
        tx_error = 1'b0; rx_data = 8'h00;
    endtask

    // Issue one buffer access and watch the following 8 cycles. rxb supplies
    // the FIFO bytes in pop order; tx bytes are packed in push order.
    task automatic do_xfer(input bit wr, input logic [1:0] hs, input logic [6:0] occ,
                           input logic [31:0] wd, input logic [31:0] rxb,
                           output int n_err, output int n_hold, output int n_get,
                           output int n_store, output logic [31:0] txw, output logic [31:0] drd);
        int k_rx;
        int k_tx;
        n_err = 0; n_hold = 0; n_get = 0; n_store = 0; txw = 32'h0; drd = 32'h0;
        k_rx = 0; k_tx = 0;
        buffer_occupancy = occ; haddr_reg = 4'h0; hsize_reg = hs;
        hwrite_reg = wr; hwdata = wd; xfer_valid = 1'b1;
        @(negedge clk);
        xfer_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (err_resp) n_err++;
            if (hold) begin
                n_hold++;
                drd = hrdata;
            end
            if (get_rx_data) begin
                n_get++;
                if (k_rx < 4) rx_data = rxb[8*k_rx +: 8];
                k_rx++;
            end
            if (store_tx_data) begin
                n_store++;
                if (k_tx < 4) txw[8*k_tx +: 8] = tx_data;
                k_tx++;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_checked(input string tag, input bit wr, input logic [1:0] hs,
                               input int occ, input logic [31:0] wd, input logic [31:0] rxb);
        int n;
        bit exp_err;
        logic [31:0] mask;
        int o_err, o_hold, o_get, o_store;
        logic [31:0] o_tx, o_rd;
        n = 1 << hs;
        if (n > 4) n = 4;
        exp_err = wr ? (occ + n > 64) : (occ < n);
        mask = 32'h0;
        for (int b = 0; b < n; b++) mask = mask | (32'hFF << (8*b));
        do_xfer(wr, hs, 7'(occ), wd, rxb, o_err, o_hold, o_get, o_store, o_tx, o_rd);
        check({tag, "_err_resp"}, o_err, exp_err ? 1 : 0);
        check({tag, "_hold"}, o_hold, exp_err ? 0 : n + 1);
        check({tag, "_get"}, o_get, (!exp_err && !wr) ? n : 0);
        check({tag, "_store"}, o_store, (!exp_err && wr) ? n : 0);
        check({tag, "_txbytes"}, o_tx, (!exp_err && wr) ? (wd & mask) : 32'h0);
        check({tag, "_hrdata"}, o_rd, (!exp_err && !wr) ? (rxb & mask) : 32'h0);
    endtask

    initial begin
        int o_err, o_hold, o_get, o_store;
        logic [31:0] o_tx, o_rd;
        int stores;

        //                pkt rdy rxe txe rxa txa occ xv wr addr wd     exp_rd   txp
        tbl[0]  = '{3'd0, 0, 0, 0, 0, 0, 7'd5, 0, 0, 4'h0, 8'h00, 16'h0000, 2'd0};
        tbl[1]  = '{3'd0, 0, 0, 0, 0, 0, 7'd5, 1, 0, 4'h8, 8'h00, 16'h0005, 2'd0};
        tbl[2]  = '{3'd0, 0, 0, 0, 0, 0, 7'd5, 1, 0, 4'h4, 8'h00, 16'h0001, 2'd0};
        tbl[3]  = '{3'd1, 1, 0, 0, 0, 0, 7'd5, 0, 0, 4'h0, 8'h00, 16'h0000, 2'd0};
        tbl[4]  = '{3'd0, 1, 0, 0, 0, 0, 7'd5, 1, 0, 4'h4, 8'h00, 16'h0003, 2'd0};
        tbl[5]  = '{3'd4, 1, 0, 0, 0, 0, 7'd5, 1, 0, 4'h4, 8'h00, 16'h0003, 2'd0};
        tbl[6]  = '{3'd0, 0, 0, 0, 1, 0, 7'd0, 1, 0, 4'h4, 8'h00, 16'h0011, 2'd0};
        tbl[7]  = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'h4, 8'h00, 16'h0110, 2'd0};
        tbl[8]  = '{3'd3, 1, 0, 0, 0, 0, 7'd0, 1, 0, 4'h4, 8'h00, 16'h0010, 2'd0};
        tbl[9]  = '{3'd0, 0, 1, 0, 0, 0, 7'd0, 1, 0, 4'h6, 8'h00, 16'h0000, 2'd0};
        tbl[10] = '{3'd0, 0, 0, 1, 0, 0, 7'd0, 1, 0, 4'h6, 8'h00, 16'h0001, 2'd0};
        tbl[11] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 4'h6, 8'h00, 16'h0000, 2'd0};
        tbl[12] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'h6, 8'h00, 16'h0100, 2'd0};
        tbl[13] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'h6, 8'h00, 16'h0000, 2'd0};
        tbl[14] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 1, 4'hC, 8'h06, 16'h0000, 2'd0};
        tbl[15] = '{3'd0, 0, 0, 0, 0, 1, 7'd0, 1, 0, 4'hC, 8'h00, 16'h0006, 2'd2};
        tbl[16] = '{3'd0, 0, 0, 0, 0, 1, 7'd0, 1, 0, 4'hC, 8'h00, 16'h0000, 2'd0};
        tbl[17] = '{3'd0, 0, 0, 0, 0, 1, 7'd0, 1, 1, 4'hC, 8'h03, 16'h0000, 2'd0};
        tbl[18] = '{3'd0, 0, 0, 0, 0, 1, 7'd0, 1, 0, 4'hC, 8'h00, 16'h0003, 2'd3};
        tbl[19] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'h4, 8'h00, 16'h0208, 2'd3};
        tbl[20] = '{3'd0, 0, 0, 0, 0, 1, 7'd0, 1, 1, 4'hC, 8'h01, 16'h0000, 2'd3};
        tbl[21] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'hC, 8'h00, 16'h0001, 2'd1};
        tbl[22] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 1, 4'h4, 8'hFF, 16'h0000, 2'd1};
        tbl[23] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'h4, 8'h00, 16'h0008, 2'd1};
        tbl[24] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'hA, 8'h00, 16'h0000, 2'd1};
        tbl[25] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 1, 4'hD, 8'h00, 16'h0000, 2'd1};
        tbl[26] = '{3'd0, 0, 0, 0, 0, 0, 7'd0, 1, 0, 4'hD, 8'h00, 16'h0000, 2'd1};

        // Reset: outputs stay 0 even with a buffer write presented across an edge.
        idle_inputs();
        n_rst = 1'b0;
        buffer_occupancy = 7'd5;
        hwrite_reg = 1'b1; xfer_valid = 1'b1; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        check("reset_ctrl", {hold, get_rx_data, store_tx_data, err_resp, clear, d_mode}, 32'h0);
        check("reset_tx", {tx_packet, tx_data}, 32'h0);
        check("reset_hrdata", hrdata, 32'h0);
        idle_inputs();
        buffer_occupancy = 7'd0;
        n_rst = 1'b1;
        @(negedge clk);

        // Register file vectors, one per cycle.
        for (int i = 0; i < 27; i++) begin
            rx_packet = tbl[i].pkt; rx_data_ready = tbl[i].rdy;
            rx_error = tbl[i].rxe; tx_error = tbl[i].txe;
            rx_transfer_active = tbl[i].rxa; tx_transfer_active = tbl[i].txa;
            buffer_occupancy = tbl[i].occ; xfer_valid = tbl[i].xv;
            hwrite_reg = tbl[i].wr; haddr_reg = tbl[i].addr; hwdata = {24'h0, tbl[i].wd};
            #1;
            check($sformatf("vec%0d_hrdata", i), hrdata, {16'h0, tbl[i].exp_rd});
            check($sformatf("vec%0d_tx_packet", i), tx_packet, tbl[i].exp_txp);
            check($sformatf("vec%0d_d_mode", i), d_mode, tbl[i].txa);
            @(negedge clk);
        end
        idle_inputs();

        // 4-byte buffer read.
        do_xfer(1'b0, 2'd2, 7'd10, 32'h0, 32'h44332211, o_err, o_hold, o_get, o_store, o_tx, o_rd);
        check("rd4_get", o_get, 4);
        check("rd4_hold", o_hold, 5);
        check("rd4_hrdata", o_rd, 32'h44332211);
        check("rd4_err_resp", o_err, 0);

        // Halfword write.
        do_xfer(1'b1, 2'd1, 7'd0, 32'hAABBCCDD, 32'h0, o_err, o_hold, o_get, o_store, o_tx, o_rd);
        check("wr2_store", o_store, 2);
        check("wr2_bytes", o_tx, 32'h0000CCDD);
        check("wr2_hold", o_hold, 3);

        // Refused transfers.
        do_xfer(1'b0, 2'd2, 7'd3, 32'h0, 32'h0, o_err, o_hold, o_get, o_store, o_tx, o_rd);
        check("rd_under_err_resp", o_err, 1);
        check("rd_under_hold", o_hold, 0);
        check("rd_under_get", o_get, 0);
        do_xfer(1'b1, 2'd2, 7'd62, 32'h01020304, 32'h0, o_err, o_hold, o_get, o_store, o_tx, o_rd);
        check("wr_over_err_resp", o_err, 1);
        check("wr_over_hold", o_hold, 0);
        check("wr_over_store", o_store, 0);

        // Boundaries that just fit.
        run_checked("wr_fit", 1'b1, 2'd2, 60, 32'hCAFEF00D, 32'h0);
        run_checked("rd_fit", 1'b0, 2'd2, 4, 32'h0, 32'h8899AABB);
        run_checked("rd_sz3", 1'b0, 2'd3, 9, 32'h0, 32'h01234567);
        run_checked("rd_byte", 1'b0, 2'd0, 1, 32'h0, 32'hFFFFFF5A);

        // Flush: occupancy stays at 8 for 5 cycles, then reaches 0.
        buffer_occupancy = 7'd8;
        xfer_valid = 1'b1; hwrite_reg = 1'b1; haddr_reg = 4'hD; hwdata = 32'h01;
        #1;
        check("flush_clear_wcycle", clear, 0);
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            buffer_occupancy = (c <= 5) ? 7'd8 : 7'd0;
            xfer_valid = (c == 1); hwrite_reg = 1'b0; haddr_reg = 4'hD;
            #1;
            if (c == 1) check("flush_reg_active", hrdata, 32'h01);
            check($sformatf("flush_clear_c%0d", c), clear, (c <= 6) ? 1 : 0);
            @(negedge clk);
        end
        xfer_valid = 1'b1; hwrite_reg = 1'b0; haddr_reg = 4'hD;
        #1;
        check("flush_reg_after", hrdata, 32'h0);
        @(negedge clk);
        idle_inputs();

        // Randomized buffer accesses, biased towards the refusal boundaries.
        for (int t = 0; t < 40; t++) begin
            bit wr;
            logic [1:0] hs;
            int n, occ;
            wr = 1'($urandom % 2);
            hs = 2'($urandom % 4);
            n = 1 << hs;
            if (n > 4) n = 4;
            occ = $urandom_range(0, 64);
            if ($urandom % 2 == 0) begin
                occ = wr ? (64 - n + $urandom_range(0, 1)) : (n - $urandom_range(0, 1));
            end
            run_checked($sformatf("rnd%0d", t), wr, hs, occ, $urandom, $urandom);
        end

        // Reset during byte 1 of a word write.
        buffer_occupancy = 7'd0;
        xfer_valid = 1'b1; hwrite_reg = 1'b1; haddr_reg = 4'h0; hsize_reg = 2'd2;
        hwdata = 32'h12345678;
        @(negedge clk);
        xfer_valid = 1'b0;
        #1;
        check("rst_mid_byte0", {store_tx_data, tx_data}, {1'b1, 8'h78});
        @(negedge clk);
        #1;
        check("rst_mid_byte1", {store_tx_data, tx_data}, {1'b1, 8'h56});
        n_rst = 1'b0;
        #1;
        check("rst_mid_ctrl", {hold, get_rx_data, store_tx_data, err_resp, clear, d_mode}, 32'h0);
        check("rst_mid_tx", {tx_packet, tx_data}, 32'h0);
        check("rst_mid_hrdata", hrdata, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        stores = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (store_tx_data || hold) stores++;
            @(negedge clk);
        end
        check("rst_mid_no_resume", stores, 0);
        run_checked("post_rst_wr", 1'b1, 2'd2, 0, 32'h9ABCDEF0, 32'h0);
        run_checked("post_rst_rd", 1'b0, 2'd1, 20, 32'h0, 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
